port_wr_frontend: RTL and testbench

//  Per-port ingress stage directly upstream of the port write backend. Accepts a packet stream
//  (sop / vld / eop) from the port, parses the header word and buffers header and payload.

---
 rtl/port_pkg.sv | 44 ++++
 rtl/port_wr_fifo.sv | 73 +++++++
 rtl/port_wr_frontend.sv | 182 ++++++++++++++++++
 tb/tb_port_wr_frontend.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_pkg.sv
`default_nettype none
// ============================================================================
// Module : port_pkg
// Brief  : Shared header layout, FIFO entry format and write-frontend states.
// Rev    : 1.0 - initial release
// ============================================================================
package port_pkg;

  localparam int unsigned DATA_W        = 16;
  localparam int unsigned HDR_DEST_LSB  = 0;
  localparam int unsigned HDR_DEST_W    = 4;
  localparam int unsigned HDR_PRIOR_LSB = 4;
  localparam int unsigned HDR_PRIOR_W   = 3;
  localparam int unsigned HDR_LEN_LSB   = 7;
  localparam int unsigned HDR_LEN_W     = 9;

  typedef struct packed {
    logic [HDR_LEN_W-1:0]   length;
    logic [HDR_PRIOR_W-1:0] prior;
    logic [HDR_DEST_W-1:0]  dest;
  } port_hdr_t;

  typedef struct packed {
    logic              hdr;
    logic              last;
    logic [DATA_W-1:0] data;
  } wr_fifo_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } wr_fe_state_t;

  function automatic port_hdr_t parse_hdr(input logic [DATA_W-1:0] word);
    port_hdr_t h;
    h.dest   = word[HDR_DEST_LSB  +: HDR_DEST_W];
    h.prior  = word[HDR_PRIOR_LSB +: HDR_PRIOR_W];
    h.length = word[HDR_LEN_LSB   +: HDR_LEN_W];
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/port_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module : port_wr_fifo
// Brief  : Single-clock FIFO of wr_fifo_entry_t; a same-edge pop frees a slot
//          for a push even when full.
// Rev    : 1.0 - initial release
// ============================================================================
module port_wr_fifo
  import port_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wr_fifo_entry_t         push_data,
  input  logic                   pop,
  output wr_fifo_entry_t         pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wr_fifo_entry_t mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push_ok;
  logic           pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/port_wr_frontend.sv
`default_nettype none
// ============================================================================
// Module : port_wr_frontend
// Brief  : Per-port ingress parser/buffer feeding the port write backend.
// Config : PORT_WR_LEN_CHECK_EN enables payload-length checking (err_length).
// Rev    : 1.0 - initial release
// ============================================================================
module port_wr_frontend
  import port_pkg::*;
#(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned FULL_MARGIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_sop,
  input  logic        wr_vld,
  input  logic [15:0] wr_data,
  input  logic        wr_eop,
  output logic        wr_full,
  input  logic        xfer_ready,
  output logic        xfer_data_vld,
  output logic [15:0] xfer_data,
  output logic        end_of_packet,
  output logic [3:0]  cur_dest_port,
  output logic [2:0]  cur_prior,
  output logic [8:0]  cur_length,
  output logic        err_overflow,
  output logic        err_proto,
  output logic        err_length
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_CNT = CW'(FULL_MARGIN);

  wr_fe_state_t   state_q, state_d;
  logic           xfer_data_vld_q, xfer_data_vld_d;
  logic [15:0]    xfer_data_q, xfer_data_d;
  logic           end_of_packet_q, end_of_packet_d;
  port_hdr_t      cur_hdr_q, cur_hdr_d;
  logic           err_overflow_q, err_overflow_d;
  logic           err_proto_q, err_proto_d;

  logic           hdr_beat;
  logic           pay_beat;
  logic           eop_beat;
  logic           push;
  logic           pop;
  wr_fifo_entry_t push_entry;
  wr_fifo_entry_t head_entry;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  assign hdr_beat   = (state_q == HEAD) && wr_vld;
  assign pay_beat   = (state_q == BODY) && wr_vld;
  assign eop_beat   = pay_beat && wr_eop;
  assign push       = hdr_beat || pay_beat;
  assign push_entry = '{hdr: hdr_beat, last: eop_beat, data: wr_data};
  // Headers drain regardless of xfer_ready: they only load cur_*, never the backend.
  assign pop        = !fifo_empty && (head_entry.hdr || xfer_ready);
  assign wr_full    = ((FULL_CNT - fifo_count) <= MARGIN_CNT);

  port_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d         = state_q;
    err_proto_d     = 1'b0;
    err_overflow_d  = push && fifo_full && !pop;
    cur_hdr_d       = cur_hdr_q;
    xfer_data_d     = xfer_data_q;
    xfer_data_vld_d = 1'b0;
    end_of_packet_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_sop)            state_d     = HEAD;
        if (wr_vld || wr_eop)  err_proto_d = 1'b1;
      end
      HEAD: begin
        if (wr_sop) err_proto_d = 1'b1;
        if (wr_vld) state_d     = BODY;
      end
      BODY: begin
        if (wr_sop)   err_proto_d = 1'b1;
        // A dropped last beat still closes the packet.
        if (eop_beat) state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      if (head_entry.hdr) begin
        cur_hdr_d = parse_hdr(head_entry.data);
      end else begin
        xfer_data_vld_d = 1'b1;
        xfer_data_d     = head_entry.data;
        end_of_packet_d = head_entry.last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      xfer_data_vld_q <= 1'b0;
      xfer_data_q     <= '0;
      end_of_packet_q <= 1'b0;
      cur_hdr_q       <= '0;
      err_overflow_q  <= 1'b0;
      err_proto_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      xfer_data_vld_q <= xfer_data_vld_d;
      xfer_data_q     <= xfer_data_d;
      end_of_packet_q <= end_of_packet_d;
      cur_hdr_q       <= cur_hdr_d;
      err_overflow_q  <= err_overflow_d;
      err_proto_q     <= err_proto_d;
    end
  end

  assign xfer_data_vld = xfer_data_vld_q;
  assign xfer_data     = xfer_data_q;
  assign end_of_packet = end_of_packet_q;
  assign cur_dest_port = cur_hdr_q.dest;
  assign cur_prior     = cur_hdr_q.prior;
  assign cur_length    = cur_hdr_q.length;
  assign err_overflow  = err_overflow_q;
  assign err_proto     = err_proto_q;

`ifdef PORT_WR_LEN_CHECK_EN
  logic [HDR_LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic [HDR_LEN_W-1:0] hdr_len_q, hdr_len_d;
  logic                 err_length_q, err_length_d;

  // Counts every payload beat the FSM accepts, including ones the FIFO drops.
  always_comb begin
    len_cnt_d    = len_cnt_q;
    hdr_len_d    = hdr_len_q;
    err_length_d = 1'b0;
    if (hdr_beat) begin
      hdr_len_d = wr_data[HDR_LEN_LSB +: HDR_LEN_W];
      len_cnt_d = '0;
    end else if (pay_beat) begin
      len_cnt_d = len_cnt_q + HDR_LEN_W'(1);
      if (wr_eop && (len_cnt_d != hdr_len_q)) err_length_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_cnt_q    <= '0;
      hdr_len_q    <= '0;
      err_length_q <= 1'b0;
    end else begin
      len_cnt_q    <= len_cnt_d;
      hdr_len_q    <= hdr_len_d;
      err_length_q <= err_length_d;
    end
  end

  assign err_length = err_length_q;
`else
  assign err_length = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_port_wr_frontend.sv
`default_nettype none
// ============================================================================
// Module : tb_port_wr_frontend
// Brief  : Directed self-checking bench for port_wr_frontend (DEPTH 32, margin 4).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_port_wr_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_sop, wr_vld, wr_eop, xfer_ready;
  logic [15:0] wr_data;
  logic        wr_full, xfer_data_vld, end_of_packet;
  logic [15:0] xfer_data;
  logic [3:0]  cur_dest_port;
  logic [2:0]  cur_prior;
  logic [8:0]  cur_length;
  logic        err_overflow, err_proto, err_length;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [16:0] obs [$];
  int n_ovf   = 0;
  int n_proto = 0;
  int n_len   = 0;
  int n_stray = 0;

`ifdef PORT_WR_LEN_CHECK_EN
  localparam logic LEN_EXP = 1'b1;
`else
  localparam logic LEN_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  port_wr_frontend #(
    .DEPTH       (32),
    .FULL_MARGIN (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_sop        (wr_sop),
    .wr_vld        (wr_vld),
    .wr_data       (wr_data),
    .wr_eop        (wr_eop),
    .wr_full       (wr_full),
    .xfer_ready    (xfer_ready),
    .xfer_data_vld (xfer_data_vld),
    .xfer_data     (xfer_data),
    .end_of_packet (end_of_packet),
    .cur_dest_port (cur_dest_port),
    .cur_prior     (cur_prior),
    .cur_length    (cur_length),
    .err_overflow  (err_overflow),
    .err_proto     (err_proto),
    .err_length    (err_length)
  );

  // Output stream and error pulses are recorded mid-cycle.
  always @(negedge clk) begin
    if (xfer_data_vld === 1'b1) obs.push_back({end_of_packet, xfer_data});
    if (err_overflow === 1'b1) n_ovf++;
    if (err_proto === 1'b1) n_proto++;
    if (err_length === 1'b1) n_len++;
    if (end_of_packet === 1'b1 && xfer_data_vld !== 1'b1) n_stray++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic sop, input logic vld, input logic eop, input logic [15:0] d);
    wr_sop  = sop;
    wr_vld  = vld;
    wr_eop  = eop;
    wr_data = d;
    tick();
    wr_sop  = 1'b0;
    wr_vld  = 1'b0;
    wr_eop  = 1'b0;
    wr_data = 16'h0;
  endtask

  task automatic test_reset();
    logic [37:0] v;
    rst = 1'b1; wr_sop = 1'b0; wr_vld = 1'b0; wr_eop = 1'b0; wr_data = 16'h0; xfer_ready = 1'b1;
    idle(3);
    v = {xfer_data_vld, end_of_packet, xfer_data, cur_dest_port, cur_prior, cur_length,
         err_overflow, err_proto, err_length, wr_full};
    n_cmp++;
    if (v !== 38'd0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", v); end
    rst = 1'b0;
    idle(2);
    v = {xfer_data_vld, end_of_packet, xfer_data, cur_dest_port, cur_prior, cur_length,
         err_overflow, err_proto, err_length, wr_full};
    n_cmp++;
    if (v !== 38'd0) begin n_fail++; $display("FAIL idle_after_reset got=%h want=0", v); end
  endtask

  task automatic test_basic();
    int base;
    logic [16:0] exp;
    base = obs.size();
    xfer_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0283);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, (i == 4), 16'hA000 + 16'(i));
      if (i == 0) begin
        n_cmp++;
        if ({cur_dest_port, cur_prior, cur_length, xfer_data_vld} !== {4'd3, 3'd0, 9'd5, 1'b0}) begin
          n_fail++;
          $display("FAIL basic_hdr_fields got=%0d/%0d/%0d vld=%b want=3/0/5 vld=0",
                   cur_dest_port, cur_prior, cur_length, xfer_data_vld);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if ({xfer_data_vld, xfer_data} !== {1'b1, 16'hA000}) begin
          n_fail++;
          $display("FAIL basic_latency got vld=%b data=%h want vld=1 data=a000", xfer_data_vld, xfer_data);
        end
      end
    end
    idle(4);
    n_cmp++;
    if (obs.size() - base !== 5) begin
      n_fail++; $display("FAIL basic_count got=%0d want=5", obs.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      exp = {(i == 4), 16'hA000 + 16'(i)};
      n_cmp++;
      if (base + i >= obs.size() || obs[base + i] !== exp) begin
        n_fail++; $display("FAIL basic_beat%0d got=%h want=%h", i,
                           (base + i < obs.size()) ? obs[base + i] : 17'h0, exp);
      end
    end
  endtask

  task automatic test_stall();
    int base;
    int sz;
    logic [16:0] exp;
    base = obs.size();
    xfer_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0283);
    drive(1'b0, 1'b1, 1'b0, 16'hB000);
    drive(1'b0, 1'b1, 1'b0, 16'hB001);
    xfer_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 16'hB002);
    sz = obs.size();
    drive(1'b0, 1'b1, 1'b0, 16'hB003);
    drive(1'b0, 1'b1, 1'b1, 16'hB004);
    idle(7);
    n_cmp++;
    if (obs.size() !== sz || wr_full !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold got beats=%0d full=%b want beats=%0d full=0",
                         obs.size(), wr_full, sz);
    end
    xfer_ready = 1'b1;
    idle(8);
    n_cmp++;
    if (obs.size() - base !== 5) begin
      n_fail++; $display("FAIL stall_count got=%0d want=5", obs.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      exp = {(i == 4), 16'hB000 + 16'(i)};
      n_cmp++;
      if (base + i >= obs.size() || obs[base + i] !== exp) begin
        n_fail++; $display("FAIL stall_beat%0d got=%h want=%h", i,
                           (base + i < obs.size()) ? obs[base + i] : 17'h0, exp);
      end
    end
  endtask

  // Header (len 39) drains at once; 39 payload beats against 32 slots -> 7 dropped.
  task automatic test_overflow();
    int base;
    int o0;
    logic [16:0] exp;
    base = obs.size();
    o0 = n_ovf;
    xfer_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h1383);
    for (int i = 0; i < 39; i++) begin
      drive(1'b0, 1'b1, (i == 38), 16'hC000 + 16'(i));
      if (i == 26) begin
        n_cmp++;
        if (wr_full !== 1'b0) begin n_fail++; $display("FAIL wr_full_free5 got=%b want=0", wr_full); end
      end
      if (i == 27) begin
        n_cmp++;
        if (wr_full !== 1'b1) begin n_fail++; $display("FAIL wr_full_free4 got=%b want=1", wr_full); end
      end
      if (i == 31) begin
        n_cmp++;
        if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_last_fit got=%b want=0", err_overflow); end
      end
      if (i == 32) begin
        n_cmp++;
        if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_first_drop got=%b want=1", err_overflow); end
      end
    end
    idle(2);
    n_cmp++;
    if (n_ovf - o0 !== 7) begin n_fail++; $display("FAIL ovf_pulses got=%0d want=7", n_ovf - o0); end
    n_cmp++;
    if ({cur_dest_port, cur_prior, cur_length} !== {4'd3, 3'd0, 9'd39}) begin
      n_fail++; $display("FAIL ovf_hdr got=%0d/%0d/%0d want=3/0/39", cur_dest_port, cur_prior, cur_length);
    end
    xfer_ready = 1'b1;
    idle(40);
    n_cmp++;
    if (obs.size() - base !== 32) begin
      n_fail++; $display("FAIL ovf_count got=%0d want=32", obs.size() - base);
    end
    for (int i = 0; i < 32; i++) begin
      exp = {1'b0, 16'hC000 + 16'(i)};
      n_cmp++;
      if (base + i >= obs.size() || obs[base + i] !== exp) begin
        n_fail++; $display("FAIL ovf_beat%0d got=%h want=%h", i,
                           (base + i < obs.size()) ? obs[base + i] : 17'h0, exp);
      end
    end
    n_cmp++;
    if (wr_full !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_full got=%b want=0", wr_full); end
  endtask

  task automatic test_proto();
    int base;
    int p0;
    base = obs.size();
    p0 = n_proto;
    xfer_ready = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 16'hDEAD);
    n_cmp++;
    if (err_proto !== 1'b1) begin n_fail++; $display("FAIL proto_vld_idle got=%b want=1", err_proto); end
    drive(1'b1, 1'b1, 1'b0, 16'hBEEF);
    n_cmp++;
    if (err_proto !== 1'b1) begin n_fail++; $display("FAIL proto_sop_vld got=%b want=1", err_proto); end
    drive(1'b0, 1'b1, 1'b0, 16'h01A5);
    n_cmp++;
    if (err_proto !== 1'b0) begin n_fail++; $display("FAIL proto_pulse_clear got=%b want=0", err_proto); end
    drive(1'b0, 1'b1, 1'b0, 16'hE000);
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if (err_proto !== 1'b1) begin n_fail++; $display("FAIL proto_sop_body got=%b want=1", err_proto); end
    drive(1'b0, 1'b1, 1'b0, 16'hE001);
    drive(1'b0, 1'b1, 1'b1, 16'hE002);
    idle(5);
    n_cmp++;
    if (n_proto - p0 !== 3) begin n_fail++; $display("FAIL proto_pulses got=%0d want=3", n_proto - p0); end
    n_cmp++;
    if ({cur_dest_port, cur_prior, cur_length} !== {4'd5, 3'd2, 9'd3}) begin
      n_fail++; $display("FAIL proto_hdr got=%0d/%0d/%0d want=5/2/3", cur_dest_port, cur_prior, cur_length);
    end
    n_cmp++;
    if (obs.size() - base !== 3 ||
        obs[base] !== {1'b0, 16'hE000} || obs[base + 1] !== {1'b0, 16'hE001} ||
        obs[base + 2] !== {1'b1, 16'hE002}) begin
      n_fail++; $display("FAIL proto_stream got count=%0d want 3 beats e000,e001,e002(eop)", obs.size() - base);
    end
  endtask

  task automatic test_length();
    int base;
    int l0;
    base = obs.size();
    l0 = n_len;
    xfer_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0201);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, (i == 5), 16'hF000 + 16'(i));
    n_cmp++;
    if (err_length !== LEN_EXP) begin n_fail++; $display("FAIL len_pulse got=%b want=%b", err_length, LEN_EXP); end
    tick();
    n_cmp++;
    if (err_length !== 1'b0) begin n_fail++; $display("FAIL len_pulse_clear got=%b want=0", err_length); end
    idle(5);
    n_cmp++;
    if (n_len - l0 !== int'(LEN_EXP)) begin
      n_fail++; $display("FAIL len_pulses got=%0d want=%0d", n_len - l0, int'(LEN_EXP));
    end
    n_cmp++;
    if (obs.size() - base !== 6 || obs[base + 5] !== {1'b1, 16'hF005}) begin
      n_fail++; $display("FAIL len_stream got count=%0d want=6 ending f005(eop)", obs.size() - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [37:0] v;
    logic [16:0] exp;
    xfer_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0283);
    drive(1'b0, 1'b1, 1'b0, 16'h9000);
    drive(1'b0, 1'b1, 1'b0, 16'h9001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    v = {xfer_data_vld, end_of_packet, xfer_data, cur_dest_port, cur_prior, cur_length,
         err_overflow, err_proto, err_length, wr_full};
    n_cmp++;
    if (v !== 38'd0) begin n_fail++; $display("FAIL reset_mid_outputs got=%h want=0", v); end
    base = obs.size();
    xfer_ready = 1'b1;
    idle(4);
    n_cmp++;
    if (obs.size() - base !== 0) begin
      n_fail++; $display("FAIL reset_mid_flushed got=%0d beats want=0", obs.size() - base);
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0312);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, (i == 5), 16'h7000 + 16'(i));
    idle(4);
    n_cmp++;
    if ({cur_dest_port, cur_prior, cur_length} !== {4'd2, 3'd1, 9'd6}) begin
      n_fail++; $display("FAIL reset_mid_hdr got=%0d/%0d/%0d want=2/1/6", cur_dest_port, cur_prior, cur_length);
    end
    n_cmp++;
    if (obs.size() - base !== 6) begin
      n_fail++; $display("FAIL reset_mid_count got=%0d want=6", obs.size() - base);
    end
    for (int i = 0; i < 6; i++) begin
      exp = {(i == 5), 16'h7000 + 16'(i)};
      n_cmp++;
      if (base + i >= obs.size() || obs[base + i] !== exp) begin
        n_fail++; $display("FAIL reset_mid_beat%0d got=%h want=%h", i,
                           (base + i < obs.size()) ? obs[base + i] : 17'h0, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_proto();
    test_length();
    test_reset_mid();
    n_cmp++;
    if (n_stray !== 0) begin n_fail++; $display("FAIL eop_without_vld got=%0d want=0", n_stray); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
